// File: rtl/wb_master_bridge.sv
// Wishbone classic single-transfer initiator. It takes one command at a time on a valid/ready port,
// runs one bus cycle with a watchdog, and returns the read data and an error flag on a response port.
module wb_master_bridge #(
  parameter int TIMEOUT  = 255,
  parameter int ERRCNT_W = 8
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic                cmd_we_i,
  input  logic [3:0]          cmd_sel_i,
  input  logic [31:0]         cmd_adr_i,
  input  logic [31:0]         cmd_dat_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [31:0]         rsp_dat_o,
  output logic                rsp_err_o,
  output logic                wbm_cyc_o,
  output logic                wbm_stb_o,
  output logic                wbm_we_o,
  output logic [3:0]          wbm_sel_o,
  output logic [31:0]         wbm_adr_o,
  output logic [31:0]         wbm_dat_o,
  input  logic [31:0]         wbm_dat_i,
  input  logic                wbm_ack_i,
  input  logic                wbm_err_i,
  output logic [ERRCNT_W-1:0] err_cnt_o
);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  localparam logic [15:0] TIMER_MAX = 16'(TIMEOUT - 1);

  state_t      state, next_state;
  logic [15:0] timer;
  logic        cmd_ready_q;
  logic        accept;
  logic        timed_out;

  assign accept    = (state == IDLE) && cmd_ready_q && cmd_valid_i;
  assign timed_out = (timer == TIMER_MAX);

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) state <= IDLE;
    else           state <= next_state;
  end

  // ack outranks err and the watchdog; any of the three ends the bus cycle
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = BUS;
      BUS:     if (wbm_ack_i || wbm_err_i || timed_out) next_state = RESP;
      RESP:    if (rsp_ready_i) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    wbm_cyc_o   = (state == BUS);
    wbm_stb_o   = (state == BUS);
    rsp_valid_o = (state == RESP);
    cmd_ready_o = cmd_ready_q;
  end

  // Ready is registered so it stays low while in reset and rises one edge after release.
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      cmd_ready_q <= 1'b0;
      wbm_we_o    <= 1'b0;
      wbm_sel_o   <= '0;
      wbm_adr_o   <= '0;
      wbm_dat_o   <= '0;
      timer       <= '0;
      rsp_dat_o   <= '0;
      rsp_err_o   <= 1'b0;
      err_cnt_o   <= '0;
    end else begin
      cmd_ready_q <= (next_state == IDLE);
      if (accept) begin
        wbm_we_o  <= cmd_we_i;
        wbm_sel_o <= cmd_sel_i;
        wbm_adr_o <= cmd_adr_i;
        wbm_dat_o <= cmd_dat_i;
        timer     <= '0;
      end
      if (state == BUS) begin
        timer <= timer + 16'd1;
        if (next_state == RESP) begin
          rsp_dat_o <= (wbm_ack_i && !wbm_we_o) ? wbm_dat_i : 32'd0;
          rsp_err_o <= !wbm_ack_i;
          if (!wbm_ack_i && (err_cnt_o != '1))
            err_cnt_o <= err_cnt_o + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_master_bridge.sv
// Self-checking bench for wb_master_bridge: a programmable Wishbone slave plus a
// word-array reference memory predicting every response, stb length and error count.
module tb_wb_master_bridge;

  localparam int TIMEOUT  = 8;
  localparam int ERRCNT_W = 8;

  localparam int M_ACK     = 0;
  localparam int M_NEVER   = 1;
  localparam int M_ERR     = 2;
  localparam int M_ACK_ERR = 3;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                cmd_valid = 1'b0;
  logic                cmd_ready;
  logic                cmd_we = 1'b0;
  logic [3:0]          cmd_sel = '0;
  logic [31:0]         cmd_adr = '0;
  logic [31:0]         cmd_dat = '0;
  logic                rsp_valid;
  logic                rsp_ready = 1'b0;
  logic [31:0]         rsp_dat;
  logic                rsp_err;
  logic                wbm_cyc, wbm_stb, wbm_we;
  logic [3:0]          wbm_sel;
  logic [31:0]         wbm_adr, wbm_dat_o;
  logic [31:0]         wbm_dat_i = '0;
  logic                wbm_ack = 1'b0;
  logic                wbm_err = 1'b0;
  logic [ERRCNT_W-1:0] err_cnt;

  int checks = 0;
  int failures = 0;

  int slave_mode = M_ACK;
  int slave_delay = 1;
  int stb_age = 0;
  logic spurious_ack = 1'b0;
  logic [31:0] slave_mem [64];
  logic [31:0] ref_mem [64];
  int exp_err_cnt = 0;

  wb_master_bridge #(.TIMEOUT(TIMEOUT), .ERRCNT_W(ERRCNT_W)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
    .cmd_sel_i(cmd_sel), .cmd_adr_i(cmd_adr), .cmd_dat_i(cmd_dat),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_dat_o(rsp_dat), .rsp_err_o(rsp_err),
    .wbm_cyc_o(wbm_cyc), .wbm_stb_o(wbm_stb), .wbm_we_o(wbm_we), .wbm_sel_o(wbm_sel),
    .wbm_adr_o(wbm_adr), .wbm_dat_o(wbm_dat_o), .wbm_dat_i(wbm_dat_i),
    .wbm_ack_i(wbm_ack), .wbm_err_i(wbm_err), .err_cnt_o(err_cnt)
  );

  always #5 clk = ~clk;

  // Slave: answers once stb has been seen high for slave_delay edges; reads return
  // junk unless acking so stray captures show up.
  always @(posedge clk) begin
    #1;
    wbm_ack = 1'b0;
    wbm_err = 1'b0;
    wbm_dat_i = $urandom;
    if (wbm_cyc && wbm_stb) begin
      stb_age++;
      if (stb_age == slave_delay) begin
        if (slave_mode == M_ACK || slave_mode == M_ACK_ERR) begin
          wbm_ack = 1'b1;
          if (slave_mode == M_ACK_ERR) wbm_err = 1'b1;
          if (wbm_we) begin
            for (int b = 0; b < 4; b++)
              if (wbm_sel[b]) slave_mem[wbm_adr[7:2]][8*b +: 8] = wbm_dat_o[8*b +: 8];
          end else begin
            wbm_dat_i = slave_mem[wbm_adr[7:2]];
          end
        end else if (slave_mode == M_ERR) begin
          wbm_err = 1'b1;
        end
      end
    end else begin
      stb_age = 0;
    end
    if (spurious_ack) wbm_ack = 1'b1;
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // Runs one full transfer; expectations come from the mode, the reference memory and the error tally.
  task automatic apply_stimulus(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                                input logic [31:0] dat, input int mode, input int delay,
                                input int rsp_delay);
    logic [31:0] exp_dat;
    logic        exp_err;
    int          exp_stb;
    int          stb_cnt;
    bit          done;
    logic [31:0] held_dat;
    exp_err = (mode == M_NEVER || mode == M_ERR);
    exp_stb = (mode == M_NEVER) ? TIMEOUT : delay;
    exp_dat = (exp_err || we) ? 32'd0 : ref_mem[adr[7:2]];
    if (!exp_err && we)
      for (int b = 0; b < 4; b++)
        if (sel[b]) ref_mem[adr[7:2]][8*b +: 8] = dat[8*b +: 8];
    if (exp_err && exp_err_cnt < 255) exp_err_cnt++;

    @(negedge clk);
    slave_mode = mode;
    slave_delay = delay;
    cmd_valid = 1'b1; cmd_we = we; cmd_sel = sel; cmd_adr = adr; cmd_dat = dat;
    done = 0;
    for (int i = 0; i < 10 && !done; i++) begin
      if (cmd_ready) done = 1;
      else @(negedge clk);
    end
    check_output("cmd_accept_wait", {31'd0, done}, 32'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    check_output("cyc_after_accept", {31'd0, wbm_cyc}, 32'd1);
    check_output("ready_in_bus", {31'd0, cmd_ready}, 32'd0);
    check_output("wbm_adr", wbm_adr, adr);

    stb_cnt = 0;
    done = 0;
    for (int i = 0; i < TIMEOUT + 10 && !done; i++) begin
      @(negedge clk);
      if (rsp_valid) done = 1;
      else if (wbm_stb) stb_cnt++;
    end
    check_output("rsp_wait", {31'd0, done}, 32'd1);
    check_output("stb_cycles", stb_cnt, exp_stb);
    check_output("rsp_dat", rsp_dat, exp_dat);
    check_output("rsp_err", {31'd0, rsp_err}, {31'd0, exp_err});
    check_output("err_cnt", {24'd0, err_cnt}, exp_err_cnt);
    held_dat = rsp_dat;
    for (int i = 0; i < rsp_delay; i++) begin
      @(negedge clk);
      check_output("bp_valid", {31'd0, rsp_valid}, 32'd1);
      check_output("bp_dat", rsp_dat, held_dat);
      check_output("bp_ready", {31'd0, cmd_ready}, 32'd0);
      check_output("bp_cyc", {31'd0, wbm_cyc}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    check_output("valid_after_hs", {31'd0, rsp_valid}, 32'd0);
    check_output("ready_after_hs", {31'd0, cmd_ready}, 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      slave_mem[i] = '0;
      ref_mem[i] = '0;
    end
    #3;
    check_output("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    check_output("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check_output("rst_cyc", {31'd0, wbm_cyc}, 32'd0);
    check_output("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_output("ready_after_release", {31'd0, cmd_ready}, 32'd1);

    $display("[TB] basic write/read");
    apply_stimulus(1'b1, 4'h1, 32'h010, 32'h000000A5, M_ACK, 1, 0);
    apply_stimulus(1'b0, 4'hF, 32'h010, 32'h0, M_ACK, 1, 0);

    $display("[TB] watchdog");
    apply_stimulus(1'b0, 4'hF, 32'h040, 32'h0, M_NEVER, 1, 0);

    $display("[TB] backpressure");
    apply_stimulus(1'b1, 4'hF, 32'h020, 32'h12345678, M_ACK, 1, 0);
    apply_stimulus(1'b0, 4'hF, 32'h020, 32'h0, M_ACK, 1, 5);

    $display("[TB] ack with err, err only");
    apply_stimulus(1'b0, 4'hF, 32'h020, 32'h0, M_ACK_ERR, 4, 0);
    apply_stimulus(1'b0, 4'hF, 32'h020, 32'h0, M_ERR, 2, 0);

    $display("[TB] error counter saturation");
    for (int i = 0; i < 300; i++)
      apply_stimulus(1'b0, 4'hF, 32'h030, 32'h0, M_ERR, 1, 0);
    check_output("err_cnt_saturated", {24'd0, err_cnt}, 32'd255);

    $display("[TB] spurious ack while idle");
    @(negedge clk);
    spurious_ack = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_output("spur_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check_output("spur_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    end
    spurious_ack = 1'b0;
    @(negedge clk);

    $display("[TB] reset during bus cycle");
    slave_mode = M_NEVER;
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_sel = 4'hF; cmd_adr = 32'h044;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    check_output("pre_reset_cyc", {31'd0, wbm_cyc}, 32'd1);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_output("async_cyc", {31'd0, wbm_cyc}, 32'd0);
    check_output("async_stb", {31'd0, wbm_stb}, 32'd0);
    check_output("async_err_cnt", {24'd0, err_cnt}, 32'd0);
    check_output("async_adr", wbm_adr, 32'd0);
    check_output("async_ready", {31'd0, cmd_ready}, 32'd0);
    exp_err_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_output("post_reset_ready", {31'd0, cmd_ready}, 32'd1);
    check_output("post_reset_valid", {31'd0, rsp_valid}, 32'd0);
    apply_stimulus(1'b1, 4'h3, 32'h008, 32'hCAFEF00D, M_ACK, 1, 0);

    $display("[TB] randomized transfers");
    for (int i = 0; i < 40; i++) begin
      int r;
      int mode;
      r = $urandom_range(0, 9);
      mode = (r < 6) ? M_ACK : (r < 8) ? M_ACK_ERR : (r < 9) ? M_ERR : M_NEVER;
      apply_stimulus(1'($urandom_range(0, 1)), 4'($urandom_range(1, 15)),
                     {24'd0, 4'($urandom_range(0, 15)), 4'd0} >> 2 << 2,
                     $urandom, mode, $urandom_range(1, 4), $urandom_range(0, 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL global_timeout observed=running expected=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
